// File: rtl/hyperbus_device_ctrl_if.sv
// HyperBus device-side link and SRAM port bundle.
// The slave modport is the device controller; master is the host/PHY plus SRAM side.
interface hyperbus_device_ctrl_if #(
    parameter int unsigned MemAddrWidth = 16
) ();
    logic                    hyper_cs_ni;
    logic [15:0]             hyper_dq_i;
    logic [15:0]             hyper_dq_o;
    logic                    hyper_dq_oe_o;
    logic [1:0]              hyper_rwds_i;
    logic [1:0]              hyper_rwds_o;
    logic                    hyper_rwds_oe_o;
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [MemAddrWidth-1:0] mem_addr_o;
    logic [1:0]              mem_be_o;
    logic [15:0]             mem_wdata_o;
    logic [15:0]             mem_rdata_i;

    modport slave (
        input  hyper_cs_ni, hyper_dq_i, hyper_rwds_i, mem_rdata_i,
        output hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output hyper_cs_ni, hyper_dq_i, hyper_rwds_i, mem_rdata_i,
        input  hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/hyperbus_device_ctrl.sv
// Device-side HyperBus responder: CA decode, initial latency, SRAM word bursts,
// ID/CR0 register space.
module hyperbus_device_ctrl #(
    parameter int unsigned MemAddrWidth   = 16,
    parameter int unsigned InitialLatency = 6,
    parameter logic [15:0] Id0            = 16'h0c81,
    parameter logic [15:0] Id1            = 16'h0001,
    parameter logic [15:0] Cr0Reset       = 16'h8f1f
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hyperbus_device_ctrl_if.slave bus
);
    localparam int unsigned LatW = $clog2(2 * InitialLatency) + 1;

    typedef logic [MemAddrWidth-1:0] addr_t;
    typedef enum logic [2:0] {
        S_IDLE, S_CA, S_LATENCY, S_REG_WR, S_READ, S_WRITE, S_DONE
    } state_e;
    typedef enum logic [1:0] {REG_ID0, REG_ID1, REG_CR0, REG_NONE} reg_e;

    state_e          state_q, state_d;
    logic            ca_phase_q, ca_phase_d;
    logic [15:0]     ca_hi_q, ca_hi_d, ca_mid_q, ca_mid_d;
    logic            is_read_q, is_read_d, is_reg_q, is_reg_d, linear_q, linear_d;
    reg_e            reg_sel_q, reg_sel_d;
    addr_t           addr_q, addr_d, addr_next;
    logic [LatW-1:0] lat_q, lat_d;
    logic [15:0]     cr0_q, cr0_d, reg_rdata;
    logic [31:0]     ca_waddr;

    // Word address {CA[44:16], CA[2:0]}; the last CA word is still on the bus.
    assign ca_waddr = {ca_hi_q[12:0], ca_mid_q, bus.hyper_dq_i[2:0]};

    function automatic addr_t next_addr(addr_t a, logic lin, logic [1:0] wl);
        addr_t mask;
        case (wl)
            2'b00:   mask = addr_t'(63);
            2'b01:   mask = addr_t'(31);
            2'b10:   mask = addr_t'(7);
            default: mask = addr_t'(15);
        endcase
        if (lin) return a + addr_t'(1);
        return (a & ~mask) | ((a + addr_t'(1)) & mask);
    endfunction

    assign addr_next = next_addr(addr_q, linear_q, cr0_q[1:0]);

    always_comb begin
        case (reg_sel_q)
            REG_ID0: reg_rdata = Id0;
            REG_ID1: reg_rdata = Id1;
            REG_CR0: reg_rdata = cr0_q;
            default: reg_rdata = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ca_phase_d = ca_phase_q;
        ca_hi_d    = ca_hi_q;
        ca_mid_d   = ca_mid_q;
        is_read_d  = is_read_q;
        is_reg_d   = is_reg_q;
        linear_d   = linear_q;
        reg_sel_d  = reg_sel_q;
        addr_d     = addr_q;
        lat_d      = lat_q;
        cr0_d      = cr0_q;
        bus.hyper_dq_o      = '0;
        bus.hyper_dq_oe_o   = 1'b0;
        bus.hyper_rwds_o    = '0;
        bus.hyper_rwds_oe_o = 1'b0;
        bus.mem_req_o       = 1'b0;
        bus.mem_we_o        = 1'b0;
        bus.mem_addr_o      = '0;
        bus.mem_be_o        = '0;
        bus.mem_wdata_o     = '0;
        // Deselect or reset silences every output in the same cycle.
        if (rst_i || bus.hyper_cs_ni) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bus.hyper_rwds_oe_o = 1'b1;
                    bus.hyper_rwds_o    = {2{cr0_q[3]}};
                    ca_hi_d    = bus.hyper_dq_i;
                    ca_phase_d = 1'b0;
                    state_d    = S_CA;
                end
                S_CA: begin
                    bus.hyper_rwds_oe_o = 1'b1;
                    bus.hyper_rwds_o    = {2{cr0_q[3]}};
                    if (!ca_phase_q) begin
                        ca_mid_d   = bus.hyper_dq_i;
                        ca_phase_d = 1'b1;
                    end else begin
                        is_read_d = ca_hi_q[15];
                        is_reg_d  = ca_hi_q[14];
                        linear_d  = ca_hi_q[13];
                        addr_d    = ca_waddr[MemAddrWidth-1:0];
                        lat_d     = cr0_q[3] ? LatW'(2 * InitialLatency - 1)
                                             : LatW'(InitialLatency - 1);
                        if (ca_waddr == 32'h0)        reg_sel_d = REG_ID0;
                        else if (ca_waddr == 32'h1)   reg_sel_d = REG_ID1;
                        else if (ca_waddr == 32'h800) reg_sel_d = REG_CR0;
                        else                          reg_sel_d = REG_NONE;
                        state_d = (!ca_hi_q[15] && ca_hi_q[14]) ? S_REG_WR : S_LATENCY;
                    end
                end
                S_LATENCY: begin
                    if (lat_q == '0) begin
                        if (is_read_q) begin
                            state_d = S_READ;
                            // Prefetch so the first word is on dq_o in the first READ cycle.
                            if (!is_reg_q) begin
                                bus.mem_req_o  = 1'b1;
                                bus.mem_addr_o = addr_q;
                                addr_d         = addr_next;
                            end
                        end else begin
                            state_d = S_WRITE;
                        end
                    end else begin
                        lat_d = lat_q - LatW'(1);
                    end
                end
                S_READ: begin
                    bus.hyper_dq_oe_o   = 1'b1;
                    bus.hyper_rwds_oe_o = 1'b1;
                    bus.hyper_rwds_o    = 2'b10;
                    bus.hyper_dq_o      = is_reg_q ? reg_rdata : bus.mem_rdata_i;
                    if (!is_reg_q) begin
                        bus.mem_req_o  = 1'b1;
                        bus.mem_addr_o = addr_q;
                        addr_d         = addr_next;
                    end
                end
                S_WRITE: begin
                    bus.mem_req_o   = 1'b1;
                    bus.mem_we_o    = 1'b1;
                    bus.mem_addr_o  = addr_q;
                    bus.mem_wdata_o = bus.hyper_dq_i;
                    bus.mem_be_o    = ~bus.hyper_rwds_i;
                    addr_d          = addr_next;
                end
                S_REG_WR: begin
                    if (reg_sel_q == REG_CR0) cr0_d = bus.hyper_dq_i;
                    state_d = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ca_phase_q <= 1'b0;
            ca_hi_q    <= '0;
            ca_mid_q   <= '0;
            is_read_q  <= 1'b0;
            is_reg_q   <= 1'b0;
            linear_q   <= 1'b0;
            reg_sel_q  <= REG_NONE;
            addr_q     <= '0;
            lat_q      <= '0;
            cr0_q      <= Cr0Reset;
        end else begin
            state_q    <= state_d;
            ca_phase_q <= ca_phase_d;
            ca_hi_q    <= ca_hi_d;
            ca_mid_q   <= ca_mid_d;
            is_read_q  <= is_read_d;
            is_reg_q   <= is_reg_d;
            linear_q   <= linear_d;
            reg_sel_q  <= reg_sel_d;
            addr_q     <= addr_d;
            lat_q      <= lat_d;
            cr0_q      <= cr0_d;
        end
    end
endmodule

// File: tb/tb_hyperbus_device_ctrl.sv
// Scoreboard bench for hyperbus_device_ctrl: a host driver queues expected SRAM
// and DQ activity from a behavioural model, a negedge monitor pops and compares.
module tb_hyperbus_device_ctrl;
    localparam int IL = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hyperbus_device_ctrl_if #(.MemAddrWidth(16)) bus ();

    hyperbus_device_ctrl #(
        .MemAddrWidth(16), .InitialLatency(IL),
        .Id0(16'h0c81), .Id1(16'h0001), .Cr0Reset(16'h8f1f)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    // SRAM attached to the DUT; read data one cycle after the request.
    bit   [15:0] sram [0:65535];
    logic [15:0] sram_rdata = '0;
    assign bus.mem_rdata_i = sram_rdata;
    always @(posedge clk) begin
        if (bus.mem_req_o) begin
            if (bus.mem_we_o) begin
                if (bus.mem_be_o[1]) sram[bus.mem_addr_o][15:8] <= bus.mem_wdata_o[15:8];
                if (bus.mem_be_o[0]) sram[bus.mem_addr_o][7:0]  <= bus.mem_wdata_o[7:0];
            end else begin
                sram_rdata <= sram[bus.mem_addr_o];
            end
        end
    end

    // Reference model state
    bit   [15:0] ref_mem [0:65535];
    logic [15:0] ref_cr0 = 16'h8f1f;
    logic [15:0] wdat [0:15];
    logic [1:0]  wmask [0:15];

    typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; logic [1:0] be; } wr_t;
    typedef struct { int cyc; logic [15:0] val; } ev_t;
    wr_t exp_wr[$];
    ev_t exp_ra[$];
    ev_t exp_rd[$];

    int checks = 0;
    int errors = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endfunction

    function automatic void unexpected(input string nm, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=none t=%0t", nm, act, $time);
    endfunction

    function automatic logic [15:0] ref_next(input logic [15:0] a, input bit lin, input logic [1:0] wl);
        int w, ai, base;
        ai = int'(a);
        case (wl)
            2'b00:   w = 64;
            2'b01:   w = 32;
            2'b10:   w = 8;
            default: w = 16;
        endcase
        if (lin) return 16'((ai + 1) % 65536);
        base = ai - (ai % w);
        return 16'(base + ((ai - base + 1) % w));
    endfunction

    function automatic logic [15:0] ref_reg(input logic [15:0] a);
        if (a == 16'h0000) return 16'h0c81;
        if (a == 16'h0001) return 16'h0001;
        if (a == 16'h0800) return ref_cr0;
        return 16'h0000;
    endfunction

    // Monitor
    int cnt = 0;
    always @(negedge clk) begin : mon
        int  cyc;
        wr_t w;
        ev_t e;
        if (rst || bus.hyper_cs_ni) begin
            check("idle_outputs",
                  {bus.hyper_dq_o, bus.hyper_dq_oe_o, bus.hyper_rwds_o, bus.hyper_rwds_oe_o,
                   bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o},
                  64'd0);
            cnt = 0;
        end else begin
            cyc = cnt;
            cnt++;
            if (cyc < 3)
                check("ca_rwds", {bus.hyper_rwds_oe_o, bus.hyper_rwds_o}, {1'b1, {2{ref_cr0[3]}}});
            else if (!bus.hyper_dq_oe_o)
                check("rwds_oe_quiet", {bus.hyper_rwds_oe_o, bus.hyper_rwds_o}, 64'd0);
            if (bus.mem_req_o && bus.mem_we_o) begin
                if (exp_wr.size() == 0) unexpected("unexpected_write", bus.mem_addr_o);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_cycle", cyc, w.cyc);
                    check("wr_addr", bus.mem_addr_o, w.addr);
                    check("wr_data", bus.mem_wdata_o, w.data);
                    check("wr_be", bus.mem_be_o, w.be);
                end
            end
            if (bus.mem_req_o && !bus.mem_we_o) begin
                if (exp_ra.size() == 0) unexpected("unexpected_read_req", bus.mem_addr_o);
                else begin
                    e = exp_ra.pop_front();
                    check("rdreq_cycle", cyc, e.cyc);
                    check("rdreq_addr", bus.mem_addr_o, e.val);
                end
            end
            if (bus.hyper_dq_oe_o) begin
                if (exp_rd.size() == 0) unexpected("unexpected_dq", bus.hyper_dq_o);
                else begin
                    e = exp_rd.pop_front();
                    check("rd_cycle", cyc, e.cyc);
                    check("rd_data", bus.hyper_dq_o, e.val);
                    check("rd_rwds", {bus.hyper_rwds_oe_o, bus.hyper_rwds_o}, 3'b110);
                end
            end
        end
    end

    // One HyperBus transaction; 'stop' = data words transferred before cs_n
    // rises (or rst_i asserts, when by_rst) - stop >= n means a full burst.
    task automatic xfer(input bit rd, input bit rg, input bit lin, input logic [15:0] a,
                        input int n, input int stop, input bit by_rst);
        int          lat, nv, total;
        logic [47:0] ca;
        logic [15:0] cw [0:2];
        logic [15:0] ad [0:16];
        lat   = ref_cr0[3] ? 2 * IL : IL;
        ca    = {rd, rg, lin, 29'(a >> 3), 13'd0, a[2:0]};
        cw[0] = ca[47:32];
        cw[1] = ca[31:16];
        cw[2] = ca[15:0];
        ad[0] = a;
        for (int i = 0; i < 16; i++) ad[i+1] = ref_next(ad[i], lin, ref_cr0[1:0]);
        nv = (stop < n) ? stop : n;
        if (!rd && rg) begin
            total = 4;
        end else begin
            total = 3 + lat + n;
            if (rd && !rg) exp_ra.push_back('{2 + lat, ad[0]});
            for (int i = 0; i < nv; i++) begin
                if (rd && !rg) begin
                    exp_ra.push_back('{3 + lat + i, ad[i+1]});
                    exp_rd.push_back('{3 + lat + i, ref_mem[ad[i]]});
                end else if (rd) begin
                    exp_rd.push_back('{3 + lat + i, ref_reg(a)});
                end else begin
                    exp_wr.push_back('{3 + lat + i, ad[i], wdat[i], ~wmask[i]});
                    if (!wmask[i][1]) ref_mem[ad[i]][15:8] = wdat[i][15:8];
                    if (!wmask[i][0]) ref_mem[ad[i]][7:0]  = wdat[i][7:0];
                end
            end
        end
        for (int c = 0; c < total; c++) begin
            @(posedge clk);
            #1;
            if (!(!rd && rg) && c == 3 + lat + stop) begin
                if (by_rst) rst = 1'b1;
                else begin
                    bus.hyper_cs_ni  = 1'b1;
                    bus.hyper_dq_i   = wdat[stop];
                    bus.hyper_rwds_i = wmask[stop];
                end
                break;
            end
            bus.hyper_cs_ni = 1'b0;
            if (c < 3) begin
                bus.hyper_dq_i   = cw[c];
                bus.hyper_rwds_i = 2'b00;
            end else if (!rd && rg) begin
                bus.hyper_dq_i   = wdat[0];
                bus.hyper_rwds_i = wmask[0];
            end else if (c >= 3 + lat) begin
                bus.hyper_dq_i   = wdat[c - 3 - lat];
                bus.hyper_rwds_i = wmask[c - 3 - lat];
            end else begin
                bus.hyper_dq_i   = 16'($urandom);
                bus.hyper_rwds_i = 2'b00;
            end
        end
        @(posedge clk);
        #1;
        bus.hyper_cs_ni  = 1'b1;
        rst              = 1'b0;
        bus.hyper_dq_i   = '0;
        bus.hyper_rwds_i = '0;
        if (!rd && rg && a == 16'h0800) ref_cr0 = wdat[0];
        if (by_rst && stop < n) ref_cr0 = 16'h8f1f;
        repeat (3) @(posedge clk);
        #1;
        check("queues_drained", {16'(exp_wr.size()), 16'(exp_ra.size()), 16'(exp_rd.size())}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, n, stop;
        bit lin, byr;
        logic [15:0] a;
        bus.hyper_cs_ni  = 1'b1;
        bus.hyper_dq_i   = '0;
        bus.hyper_rwds_i = '0;
        for (int i = 0; i < 16; i++) begin
            wdat[i]  = '0;
            wmask[i] = '0;
        end
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        xfer(1, 1, 1, 16'h0800, 1, 99, 0);                  // CR0 reads reset value
        for (int i = 0; i < 4; i++) begin
            wdat[i]  = 16'(16'h1111 * (i + 1));
            wmask[i] = 2'b00;
        end
        xfer(0, 0, 1, 16'h0010, 4, 99, 0);                  // linear write, L=12
        xfer(1, 0, 1, 16'h0010, 4, 99, 0);                  // linear read back
        wdat[0]  = 16'habcd;
        wmask[0] = 2'b10;
        xfer(0, 0, 1, 16'h0020, 1, 99, 0);                  // masked byte write
        xfer(1, 0, 1, 16'h0020, 1, 99, 0);
        xfer(1, 0, 0, 16'h000e, 6, 99, 0);                  // wrapped read, W=16
        wdat[0]  = 16'h8f17;
        wmask[0] = 2'b11;
        xfer(0, 1, 1, 16'h0800, 1, 99, 0);                  // CR0 -> 1x latency
        xfer(1, 1, 1, 16'h0000, 1, 99, 0);                  // ID0 at L=6
        for (int i = 0; i < 8; i++) begin
            wdat[i]  = 16'(16'h5a00 + i);
            wmask[i] = 2'b00;
        end
        xfer(0, 0, 1, 16'h0030, 8, 2, 0);                   // abort after 2 words
        xfer(1, 0, 1, 16'h0030, 4, 99, 0);
        xfer(1, 0, 1, 16'h0010, 4, 2, 1);                   // reset mid-read
        xfer(1, 1, 1, 16'h0800, 1, 99, 0);

        for (int t = 0; t < 80; t++) begin
            k    = $urandom_range(0, 9);
            n    = $urandom_range(1, 8);
            lin  = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 4) == 0) ? 16'(16'hfff8 + $urandom_range(0, 7))
                                              : 16'($urandom_range(0, 63));
            stop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : 99;
            byr  = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 16; i++) begin
                wdat[i]  = 16'($urandom);
                wmask[i] = 2'($urandom_range(0, 3));
            end
            if (k <= 3) xfer(0, 0, lin, a, n, stop, byr);
            else if (k <= 7) xfer(1, 0, lin, a, n, stop, byr);
            else if (k == 8) xfer(0, 1, 1, 16'h0800, 1, 99, 0);
            else begin
                case ($urandom_range(0, 3))
                    0: a = 16'h0000;
                    1: a = 16'h0001;
                    2: a = 16'h0800;
                    default: a = 16'($urandom_range(2, 255));
                endcase
                xfer(1, 1, 1, a, n, stop, byr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
